brightness_ctrl: RTL and testbench

Front-end controller for the PWM LED brightness path.
- Conditions two raw push-buttons (synchronise, debounce) and runs a press/hold/auto-repeat state machine.
- Maintains a saturating brightness level register.
- Drives the LED through a glitch-free PWM whose duty updates only at period boundaries.
- Sits between the board buttons and the LED pin; replaces ad-hoc button handling in the LED datapath.

---
 rtl/brightness_pkg.sv | 34 +++
 rtl/brightness_ctrl_if.sv | 20 ++
 rtl/brightness_ctrl_button_debounce.sv | 46 ++++
 rtl/brightness_ctrl.sv | 174 +++++++++++++++++
 tb/tb_brightness_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/brightness_pkg.sv
// Shared types and constants for the LED brightness controller.
// Holds the FSM state enum, the default parameter set, the constants derived
// from those defaults, and a width helper that lets each module size its own
// counters from its actual parameter values.
package brightness_pkg;

  // Default configuration, used as parameter defaults by the modules
  localparam int unsigned LEVEL_W_DEF      = 4;
  localparam int unsigned DEBOUNCE_CYC_DEF = 8;
  localparam int unsigned REPEAT_DELAY_DEF = 32;
  localparam int unsigned REPEAT_RATE_DEF  = 8;
  localparam int unsigned INIT_LEVEL_DEF   = 8;

  // Minimum bit width able to hold max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Constants for the default configuration
  localparam int unsigned LEVEL_MAX = (1 << LEVEL_W_DEF) - 1;
  localparam int unsigned TIMER_W   = cnt_width((REPEAT_DELAY_DEF > REPEAT_RATE_DEF) ?
                                                REPEAT_DELAY_DEF : REPEAT_RATE_DEF);
  localparam int unsigned DB_CNT_W  = cnt_width(DEBOUNCE_CYC_DEF);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD_UP = 3'd1,
    RPT_UP  = 3'd2,
    HOLD_DN = 3'd3,
    RPT_DN  = 3'd4,
    LOCK    = 3'd5
  } state_e;

endpackage

// File: rtl/brightness_ctrl_if.sv
// Board-side bundle of the brightness controller.
//   button_plus, button_minus : raw asynchronous buttons, 1 = pressed
//   level                     : current requested brightness level
//   led                       : registered PWM output
//   step                      : one-cycle pulse per accepted level change
// master = button/LED side, slave = controller.
interface brightness_ctrl_if #(
  parameter int unsigned LEVEL_W = 4
);
  logic               button_plus;
  logic               button_minus;
  logic [LEVEL_W-1:0] level;
  logic               led;
  logic               step;

  modport master (output button_plus, output button_minus,
                  input level, input led, input step);
  modport slave  (input button_plus, input button_minus,
                  output level, output led, output step);
endinterface

// File: rtl/brightness_ctrl_button_debounce.sv
// Two-flop synchroniser followed by a debouncer for one raw button.
//   clk, rst : clock, async active-high reset
//   raw      : asynchronous button input
//   db       : debounced level, flips after DEBOUNCE_CYC consecutive
//              synchronised cycles that disagree with it
module button_debounce
  import brightness_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Synchroniser, mismatch counter and debounced state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      db   <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync != db) begin
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          db  <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/brightness_ctrl.sv
// Button-driven LED brightness controller.
// Debounces two buttons, runs a press/hold/auto-repeat FSM, keeps a
// saturating level register and drives the LED with a PWM whose duty is
// captured only at the start of each period.
//   clk, rst : clock, async active-high reset
//   bus      : brightness_ctrl_if.slave (buttons in; level, led, step out)
// Optional: define BRIGHTNESS_CTRL_SOFTSTART_EN to reset the level to 0 and
// ramp it up to INIT_LEVEL one step per PWM period, with buttons ignored
// until the ramp completes.
module brightness_ctrl
  import brightness_pkg::*;
#(
  parameter int unsigned LEVEL_W      = LEVEL_W_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int unsigned INIT_LEVEL   = INIT_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  brightness_ctrl_if.slave  bus
);

  localparam int unsigned LVL_MAX = (1 << LEVEL_W) - 1;
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

  logic               db_plus, db_minus;
  logic               prev_plus, prev_minus;
  logic               rise_plus_c, rise_minus_c;
  state_e             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               up_c, dn_c;
  logic [LEVEL_W-1:0] level_q;
  logic               step_q;
  logic [LEVEL_W-1:0] pwm_cnt, shadow, duty_now_c;
  logic               led_q;
  logic               buttons_live;
  logic               ramp_inc_c;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_plus (
    .clk(clk), .rst(rst), .raw(bus.button_plus), .db(db_plus)
  );
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_minus (
    .clk(clk), .rst(rst), .raw(bus.button_minus), .db(db_minus)
  );

  assign rise_plus_c  = db_plus & ~prev_plus;
  assign rise_minus_c = db_minus & ~prev_minus;

  // FSM state, repeat timer and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      prev_plus  <= 1'b0;
      prev_minus <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      prev_plus  <= db_plus;
      prev_minus <= db_minus;
    end
  end

  // Next state and step requests; both-pressed always wins
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    up_c      = 1'b0;
    dn_c      = 1'b0;
    if (db_plus && db_minus) begin
      state_nxt = LOCK;
    end else begin
      case (state)
        IDLE: begin
          if (rise_plus_c) begin
            up_c      = 1'b1;
            state_nxt = HOLD_UP;
            timer_nxt = TMR_W'(REPEAT_DELAY);
          end else if (rise_minus_c) begin
            dn_c      = 1'b1;
            state_nxt = HOLD_DN;
            timer_nxt = TMR_W'(REPEAT_DELAY);
          end
        end
        HOLD_UP, RPT_UP: begin
          if (!db_plus) begin
            state_nxt = IDLE;
          end else if (timer == TMR_W'(1)) begin
            up_c      = 1'b1;
            state_nxt = RPT_UP;
            timer_nxt = TMR_W'(REPEAT_RATE);
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end
        HOLD_DN, RPT_DN: begin
          if (!db_minus) begin
            state_nxt = IDLE;
          end else if (timer == TMR_W'(1)) begin
            dn_c      = 1'b1;
            state_nxt = RPT_DN;
            timer_nxt = TMR_W'(REPEAT_RATE);
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end
        LOCK: begin
          if (!db_plus && !db_minus) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef BRIGHTNESS_CTRL_SOFTSTART_EN
  localparam logic [LEVEL_W-1:0] LEVEL_RST = '0;
  logic ramp_done;

  // Ramp is finished once the level has climbed to INIT_LEVEL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ramp_done <= 1'b0;
    else if (level_q == LEVEL_W'(INIT_LEVEL)) ramp_done <= 1'b1;
  end

  assign buttons_live = ramp_done;
  assign ramp_inc_c   = !ramp_done && (level_q != LEVEL_W'(INIT_LEVEL)) &&
                        (pwm_cnt == LEVEL_W'(LVL_MAX));
`else
  localparam logic [LEVEL_W-1:0] LEVEL_RST = LEVEL_W'(INIT_LEVEL);

  assign buttons_live = 1'b1;
  assign ramp_inc_c   = 1'b0;
`endif

  // Saturating level register; step pulses only when the level moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= LEVEL_RST;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (ramp_inc_c || (buttons_live && up_c && level_q != LEVEL_W'(LVL_MAX))) begin
        level_q <= level_q + LEVEL_W'(1);
        step_q  <= 1'b1;
      end else if (buttons_live && dn_c && level_q != '0) begin
        level_q <= level_q - LEVEL_W'(1);
        step_q  <= 1'b1;
      end
    end
  end

  // In the counter-0 cycle the shadow is being reloaded, so use the level directly
  assign duty_now_c = (pwm_cnt == '0) ? level_q : shadow;

  // Free-running PWM counter, period-boundary duty capture, registered LED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      led_q   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + LEVEL_W'(1);
      if (pwm_cnt == '0) shadow <= level_q;
      led_q <= (pwm_cnt < duty_now_c);
    end
  end

  assign bus.level = level_q;
  assign bus.step  = step_q;
  assign bus.led   = led_q;

endmodule

// File: tb/tb_brightness_ctrl.sv
// Directed self-checking bench for brightness_ctrl (default build).
module tb_brightness_ctrl;
  import brightness_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  brightness_ctrl_if #(.LEVEL_W(4)) bif ();

  brightness_ctrl #(
    .LEVEL_W(4), .DEBOUNCE_CYC(4), .REPEAT_DELAY(16), .REPEAT_RATE(4), .INIT_LEVEL(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bif.button_plus  = 1'b0;
    bif.button_minus = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int highs;
    apply_reset();
    checks++;
    if (bif.level !== 4'd8) begin failures++; $display("FAIL reset_level: got %0d expected 8", bif.level); end
    checks++;
    if (bif.led !== 1'b0) begin failures++; $display("FAIL reset_led: got %b expected 0", bif.led); end
    checks++;
    if (bif.step !== 1'b0) begin failures++; $display("FAIL reset_step: got %b expected 0", bif.step); end
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
    repeat (16) tick();
    highs = 0;
    for (int i = 0; i < 16; i++) begin tick(); if (bif.led === 1'b1) highs++; end
    checks++;
    if (highs != 8) begin failures++; $display("FAIL reset_duty: got %0d expected 8 of 16", highs); end
  endtask

  task automatic test_short_press();
    int steps, first, highs;
    steps = 0; first = -1;
    bif.button_plus = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 10) bif.button_plus = 1'b0;
      if (bif.step === 1'b1) begin steps++; if (first < 0) first = i; end
    end
    checks++;
    if (steps != 1) begin failures++; $display("FAIL short_steps: got %0d expected 1", steps); end
    checks++;
    if (first != 7) begin failures++; $display("FAIL short_latency: got %0d expected 7", first); end
    checks++;
    if (bif.level !== 4'd9) begin failures++; $display("FAIL short_level: got %0d expected 9", bif.level); end
    repeat (16) tick();
    highs = 0;
    for (int i = 0; i < 16; i++) begin tick(); if (bif.led === 1'b1) highs++; end
    checks++;
    if (highs != 9) begin failures++; $display("FAIL short_duty: got %0d expected 9 of 16", highs); end
  endtask

  task automatic test_hold_saturate();
    int steps;
    int at [0:15];
    apply_reset();
    steps = 0;
    bif.button_plus = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bif.step === 1'b1) begin if (steps < 16) at[steps] = i; steps++; end
    end
    checks++;
    if (steps != 7) begin failures++; $display("FAIL hold_steps: got %0d expected 7", steps); end
    checks++;
    if (at[0] != 7) begin failures++; $display("FAIL hold_t0: got %0d expected 7", at[0]); end
    checks++;
    if (at[1] != 23) begin failures++; $display("FAIL hold_t1: got %0d expected 23", at[1]); end
    checks++;
    if (at[2] != 27) begin failures++; $display("FAIL hold_t2: got %0d expected 27", at[2]); end
    checks++;
    if (at[6] != 43) begin failures++; $display("FAIL hold_t6: got %0d expected 43", at[6]); end
    checks++;
    if (bif.level !== 4'd15) begin failures++; $display("FAIL hold_level: got %0d expected 15", bif.level); end
    checks++;
    if (dut.state !== RPT_UP) begin failures++; $display("FAIL hold_state: got %0d expected RPT_UP", dut.state); end
    bif.button_plus = 1'b0;
    repeat (20) tick();
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL hold_release_state: got %0d expected IDLE", dut.state); end
  endtask

  task automatic test_bounce();
    int steps;
    steps = 0;
    for (int i = 0; i < 40; i++) begin
      bif.button_minus = (((i >> 1) & 1) == 0);
      tick();
      if (bif.step === 1'b1) steps++;
    end
    bif.button_minus = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (bif.step === 1'b1) steps++; end
    checks++;
    if (steps != 0) begin failures++; $display("FAIL bounce_steps: got %0d expected 0", steps); end
    checks++;
    if (bif.level !== 4'd15) begin failures++; $display("FAIL bounce_level: got %0d expected 15", bif.level); end
  endtask

  task automatic test_simultaneous();
    int steps;
    steps = 0;
    bif.button_plus  = 1'b1;
    bif.button_minus = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (bif.step === 1'b1) steps++; end
    checks++;
    if (dut.state !== LOCK) begin failures++; $display("FAIL simul_lock: got %0d expected LOCK", dut.state); end
    bif.button_plus = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (bif.step === 1'b1) steps++; end
    checks++;
    if (dut.state !== LOCK) begin failures++; $display("FAIL simul_half_release: got %0d expected LOCK", dut.state); end
    bif.button_minus = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (bif.step === 1'b1) steps++; end
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL simul_unlock: got %0d expected IDLE", dut.state); end
    checks++;
    if (steps != 0) begin failures++; $display("FAIL simul_no_step: got %0d expected 0", steps); end
    steps = 0;
    bif.button_minus = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 12) bif.button_minus = 1'b0;
      if (bif.step === 1'b1) steps++;
    end
    checks++;
    if (steps != 1) begin failures++; $display("FAIL simul_after_steps: got %0d expected 1", steps); end
    checks++;
    if (bif.level !== 4'd14) begin failures++; $display("FAIL simul_after_level: got %0d expected 14", bif.level); end
  endtask

  task automatic test_floor();
    int steps, highs;
    steps = 0; highs = 0;
    bif.button_minus = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (bif.step === 1'b1) steps++;
      if (i > 100 && bif.led === 1'b1) highs++;
    end
    checks++;
    if (steps != 14) begin failures++; $display("FAIL floor_steps: got %0d expected 14", steps); end
    checks++;
    if (bif.level !== 4'd0) begin failures++; $display("FAIL floor_level: got %0d expected 0", bif.level); end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL floor_led: got %0d high cycles expected 0", highs); end
    bif.button_minus = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset_mid_hold();
    int steps;
    bif.button_plus = 1'b1;
    repeat (30) tick();
    checks++;
    if (dut.state !== RPT_UP) begin failures++; $display("FAIL midrst_pre_state: got %0d expected RPT_UP", dut.state); end
    checks++;
    if (bif.level !== 4'd3) begin failures++; $display("FAIL midrst_pre_level: got %0d expected 3", bif.level); end
    rst = 1'b1;
    #1;
    checks++;
    if (bif.level !== 4'd8) begin failures++; $display("FAIL midrst_level: got %0d expected 8", bif.level); end
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state); end
    checks++;
    if (bif.led !== 1'b0 || bif.step !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs: got led=%b step=%b expected 0 0", bif.led, bif.step);
    end
    repeat (2) tick();
    bif.button_plus = 1'b0;
    rst = 1'b0;
    steps = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (bif.step === 1'b1) steps++; end
    checks++;
    if (steps != 0 || bif.level !== 4'd8) begin
      failures++; $display("FAIL midrst_after: got steps=%0d level=%0d expected 0 8", steps, bif.level);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bif.button_plus  = 1'b0;
    bif.button_minus = 1'b0;
    test_reset();
    test_short_press();
    test_hold_saturate();
    test_bounce();
    test_simultaneous();
    test_floor();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
